// File: rtl/sc_reg_randcapture_if.sv
// sc_reg_randcapture_if: random-capture request/data/handshake bundle
interface sc_reg_randcapture_if #(
  parameter int RegRANDCAPTURE_DATAWIDTH = 8
);
  logic [RegRANDCAPTURE_DATAWIDTH-1:0] SC_RegRANDCAPTURE_data_InBUS;
  logic                                SC_RegRANDCAPTURE_request_In;
  logic                                SC_RegRANDCAPTURE_ack_In;
  logic [RegRANDCAPTURE_DATAWIDTH-1:0] SC_RegRANDCAPTURE_data_OutBUS;
  logic                                SC_RegRANDCAPTURE_valid_Out;
  logic                                SC_RegRANDCAPTURE_busy_Out;
  logic                                SC_RegRANDCAPTURE_fallback_Out;
  logic [7:0]                          SC_RegRANDCAPTURE_count_OutBUS;
  modport master (
    output SC_RegRANDCAPTURE_data_InBUS, SC_RegRANDCAPTURE_request_In, SC_RegRANDCAPTURE_ack_In,
    input  SC_RegRANDCAPTURE_data_OutBUS, SC_RegRANDCAPTURE_valid_Out, SC_RegRANDCAPTURE_busy_Out,
           SC_RegRANDCAPTURE_fallback_Out, SC_RegRANDCAPTURE_count_OutBUS
  );
  modport slave (
    input  SC_RegRANDCAPTURE_data_InBUS, SC_RegRANDCAPTURE_request_In, SC_RegRANDCAPTURE_ack_In,
    output SC_RegRANDCAPTURE_data_OutBUS, SC_RegRANDCAPTURE_valid_Out, SC_RegRANDCAPTURE_busy_Out,
           SC_RegRANDCAPTURE_fallback_Out, SC_RegRANDCAPTURE_count_OutBUS
  );
endinterface

// File: rtl/sc_reg_randcapture.sv
// sc_reg_randcapture: rejection-sampled capture of a random bus with valid/ack delivery
module sc_reg_randcapture #(
  parameter int RegRANDCAPTURE_DATAWIDTH = 8,
  parameter int RegRANDCAPTURE_LIMIT     = 200,
  parameter int RegRANDCAPTURE_MAXTRY    = 4
) (
  input logic SC_RegRANDCAPTURE_CLOCK_50,
  input logic SC_RegRANDCAPTURE_RESET_InHigh,
  sc_reg_randcapture_if.slave bus
);
  localparam int DW = RegRANDCAPTURE_DATAWIDTH;
  localparam logic [DW:0]   LIM      = (DW+1)'(RegRANDCAPTURE_LIMIT);
  localparam logic [DW-1:0] FB_VAL   = DW'(RegRANDCAPTURE_LIMIT - 1);
  localparam logic [3:0]    TRY_LAST = 4'(RegRANDCAPTURE_MAXTRY - 1);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  logic [1:0]    r_state;
  logic [3:0]    r_try;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_fallback;
  logic [7:0]    r_count;
  logic          w_accept;
  logic          w_last;
  // one extra compare bit lets LIMIT = 2^DW accept every value
  assign w_accept = {1'b0, bus.SC_RegRANDCAPTURE_data_InBUS} < LIM;
  assign w_last   = r_try == TRY_LAST;
  assign bus.SC_RegRANDCAPTURE_data_OutBUS  = r_data;
  assign bus.SC_RegRANDCAPTURE_valid_Out    = r_valid;
  assign bus.SC_RegRANDCAPTURE_busy_Out     = r_busy;
  assign bus.SC_RegRANDCAPTURE_fallback_Out = r_fallback;
  assign bus.SC_RegRANDCAPTURE_count_OutBUS = r_count;
  // request/sample/hold sequencer; every output is a register updated here
  always_ff @(posedge SC_RegRANDCAPTURE_CLOCK_50 or posedge SC_RegRANDCAPTURE_RESET_InHigh) begin
    if (SC_RegRANDCAPTURE_RESET_InHigh) begin
      r_state    <= ST_IDLE;
      r_try      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_fallback <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.SC_RegRANDCAPTURE_request_In) begin
          r_state <= ST_SAMPLE;
          r_try   <= '0;
          r_busy  <= 1'b1;
        end
        ST_SAMPLE: if (w_accept || w_last) begin
          r_data     <= w_accept ? bus.SC_RegRANDCAPTURE_data_InBUS : FB_VAL;
          r_fallback <= !w_accept;
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_count    <= r_count + 8'd1;
          r_state    <= ST_HOLD;
        end else begin
          r_try <= r_try + 4'd1;
        end
        ST_HOLD: if (bus.SC_RegRANDCAPTURE_ack_In) begin
          r_valid <= 1'b0;
          r_try   <= '0;
          r_busy  <= bus.SC_RegRANDCAPTURE_request_In;
          r_state <= bus.SC_RegRANDCAPTURE_request_In ? ST_SAMPLE : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_reg_randcapture.sv
// tb_sc_reg_randcapture: table-driven directed check of the random capture block
module tb_sc_reg_randcapture;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    int req, ack, d, v, b, f, dout, cnt;
  } vec_t;
  vec_t tbl[18];

  sc_reg_randcapture_if #(.RegRANDCAPTURE_DATAWIDTH(8)) bus ();

  sc_reg_randcapture #(
    .RegRANDCAPTURE_DATAWIDTH(8),
    .RegRANDCAPTURE_LIMIT(200),
    .RegRANDCAPTURE_MAXTRY(4)
  ) dut (
    .SC_RegRANDCAPTURE_CLOCK_50(clk),
    .SC_RegRANDCAPTURE_RESET_InHigh(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int req, int ack, int d, int v, int b, int f, int dout, int cnt);
    vec_t t;
    t.req = req; t.ack = ack; t.d = d; t.v = v; t.b = b; t.f = f; t.dout = dout; t.cnt = cnt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int req, int ack, int d);
    bus.SC_RegRANDCAPTURE_request_In = 1'(req);
    bus.SC_RegRANDCAPTURE_ack_In     = 1'(ack);
    bus.SC_RegRANDCAPTURE_data_InBUS = 8'(d);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, int v, int b, int f, int dout, int cnt);
    chk({nm, ".valid"},    int'(bus.SC_RegRANDCAPTURE_valid_Out), v);
    chk({nm, ".busy"},     int'(bus.SC_RegRANDCAPTURE_busy_Out), b);
    chk({nm, ".fallback"}, int'(bus.SC_RegRANDCAPTURE_fallback_Out), f);
    chk({nm, ".data"},     int'(bus.SC_RegRANDCAPTURE_data_OutBUS), dout);
    chk({nm, ".count"},    int'(bus.SC_RegRANDCAPTURE_count_OutBUS), cnt);
  endtask

  initial begin
    //            req ack  d    v  b  f  dout cnt
    tbl[0]  = mk(1, 0,   0,   0, 1, 0,   0, 0);
    tbl[1]  = mk(0, 0,  37,   1, 0, 0,  37, 1);
    tbl[2]  = mk(0, 1,   0,   0, 0, 0,  37, 1);
    tbl[3]  = mk(1, 0,   0,   0, 1, 0,  37, 1);
    tbl[4]  = mk(0, 0, 255,   0, 1, 0,  37, 1);
    tbl[5]  = mk(0, 0, 255,   0, 1, 0,  37, 1);
    tbl[6]  = mk(0, 0, 255,   0, 1, 0,  37, 1);
    tbl[7]  = mk(0, 0, 255,   1, 0, 1, 199, 2);
    tbl[8]  = mk(0, 0,   0,   1, 0, 1, 199, 2);
    tbl[9]  = mk(1, 1,   0,   0, 1, 1, 199, 2);
    tbl[10] = mk(0, 0,  12,   1, 0, 0,  12, 3);
    tbl[11] = mk(0, 1,   0,   0, 0, 0,  12, 3);
    tbl[12] = mk(1, 0,  77,   0, 1, 0,  12, 3);
    tbl[13] = mk(0, 1, 250,   0, 1, 0,  12, 3);
    tbl[14] = mk(0, 0, 200,   0, 1, 0,  12, 3);
    tbl[15] = mk(0, 0, 199,   1, 0, 0, 199, 4);
    tbl[16] = mk(0, 1,   0,   0, 0, 0, 199, 4);
    tbl[17] = mk(0, 1,   0,   0, 0, 0, 199, 4);

    rst = 1'b1;
    drive(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk_out("post_reset_idle", 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].req, tbl[i].ack, tbl[i].d);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].b, tbl[i].f, tbl[i].dout, tbl[i].cnt);
    end

    drive(1, 0, 0);
    tick();
    chk_out("stall_req", 0, 1, 0, 199, 4);
    drive(1, 0, 50);
    tick();
    chk_out("stall_deliver", 1, 0, 0, 50, 5);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, i * 20);
      tick();
      chk_out($sformatf("stall%0d", i), 1, 0, 0, 50, 5);
    end

    #2 rst = 1'b1;
    #1 chk_out("async_reset_hold", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 0);
    tick();
    chk_out("release_idle", 0, 0, 0, 0, 0);

    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 5);
      tick();
      drive(0, 0, 5);
      tick();
      if (i == 0) chk_out("wrap_first", 1, 0, 0, 5, 1);
      if (i == 254) chk("wrap_255.count", int'(bus.SC_RegRANDCAPTURE_count_OutBUS), 255);
      drive(0, 1, 0);
      tick();
    end
    drive(0, 0, 0);
    chk_out("wrap_zero", 0, 0, 0, 5, 0);

    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    drive(1, 0, 255);
    tick();
    drive(0, 0, 255);
    tick();
    tick();
    chk_out("abort_two_rejects", 0, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_out("abort_reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("abort_idle%0d", i), 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sc_reg_randcapture.md
# sc_reg_randcapture

Downstream consumer of the pseudo-random shift-register stage. On request, it samples the free-running random bus and keeps only values below a programmable limit (rejection sampling), retrying on later cycles up to a bounded count. It then presents the accepted value to the game/register logic with a valid/ack handshake and holds it until acknowledged. It also keeps a wrap-around count of delivered values.

## Interface
- RegRANDCAPTURE_DATAWIDTH, 8: width of random input and captured output.
- RegRANDCAPTURE_LIMIT, 200: acceptance bound; a sample is accepted iff value < LIMIT. Legal range 1..2^DATAWIDTH.
- RegRANDCAPTURE_MAXTRY, 4: maximum samples per request before fallback. Legal range 1..15.

- SC_RegRANDCAPTURE_CLOCK_50  in  1  single system clock, all logic on posedge.
- SC_RegRANDCAPTURE_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_RegRANDCAPTURE_data_InBUS  in  DATAWIDTH  random value from shifter stage, new value every cycle.
- SC_RegRANDCAPTURE_request_In  in  1  level request for one value.
- SC_RegRANDCAPTURE_ack_In  in  1  consumer accepts held value.
- SC_RegRANDCAPTURE_data_OutBUS  out  DATAWIDTH  captured value, registered.
- SC_RegRANDCAPTURE_valid_Out  out  1  data_OutBUS holds a delivered value.
- SC_RegRANDCAPTURE_busy_Out  out  1  sampling in progress.
- SC_RegRANDCAPTURE_fallback_Out  out  1  current value produced by the fallback path.
- SC_RegRANDCAPTURE_count_OutBUS  out  8  number of delivered values, mod 256.

## Operation
- States: IDLE, SAMPLE, HOLD. The state register and all outputs are registered.
- IDLE: busy=0, valid=0. If request=1 at the edge, go to SAMPLE and clear the try counter.
- SAMPLE: busy=1. On each edge, compare data_InBUS against LIMIT.
  - The compare is done at DATAWIDTH+1 bits, so LIMIT=2^DATAWIDTH accepts every value.
  - Accept: data_Out<=data_In, valid<=1, fallback<=0, count<=count+1, go to HOLD.
  - Reject with try counter < MAXTRY-1: increment try counter, stay in SAMPLE.
  - Reject on the MAXTRY-th sample: data_Out<=LIMIT-1, fallback<=1, valid<=1, count<=count+1, go to HOLD.
- request is not re-checked in SAMPLE. A request dropped mid-SAMPLE still completes delivery.
- HOLD: busy=0, valid=1, data_Out and fallback frozen.
  - ack=1 and request=0: valid<=0, go to IDLE.
  - ack=1 and request=1: valid<=0, clear try counter, go to SAMPLE (back-to-back delivery).
  - ack=0: stay in HOLD. request is ignored.
- ack in IDLE or SAMPLE has no effect.
- count wraps 255 -> 0 with no flag.
- fallback stays at its last value until the next delivery overwrites it. It clears only on reset or an accepted delivery.

## Timing
- Reset (async, immediate): state=IDLE, data_Out=0, valid=0, busy=0, fallback=0, count=0, try counter=0.
- Reset asserted mid-SAMPLE or in HOLD aborts the operation and discards the value.
- After reset release, the first edge is evaluated normally.
- Latency is measured from the edge sampling request=1 in IDLE:
  - Best case: valid high after 2 edges.
  - Worst case (fallback): valid high after MAXTRY+1 edges.
- busy rises 1 edge after the request edge. busy falls on the same edge where valid rises.
- Hold to IDLE: valid low 1 edge after the ack edge.
- Back-to-back: with request held and ack pulsed in HOLD, the next value is valid 2 edges after the ack edge at the earliest.
- data_InBUS is sampled only on SAMPLE-state edges. Its values on other cycles are irrelevant.

## Test plan
Parameters for all cases: DATAWIDTH=8, LIMIT=200, MAXTRY=4.
1. Reset: assert RESET_InHigh between edges -> all outputs 0 immediately without a clock edge; release -> stay in IDLE with request=0.
2. request=1 for 1 cycle, data_In=37 -> busy=1 after edge 1; valid=1, data_Out=37, count=1, busy=0 after edge 2; ack=1 -> valid=0 next edge.
3. data_In sequence 250, 210, 37 during SAMPLE -> valid after edge 4, data_Out=37, fallback=0, count increments by 1.
4. data_In held at 255 -> after 4 rejections: valid after edge 5, data_Out=199, fallback=1; the next accepted delivery of 12 clears fallback to 0.
5. HOLD with ack=1, request=1 -> SAMPLE next edge, new value valid 2 edges after ack; HOLD with ack=0, request=1 for 10 cycles -> data_Out unchanged, count unchanged.
6. 256 deliveries with data_In=5 -> count returns to 0. Reset asserted in SAMPLE after 2 rejections -> valid never rises, count=0.
